// File: rtl/sram_bank_pkg.sv
// Shared state encoding, width helpers and the no-cell read pattern for the SRAM bank.
// Also carries StClear for builds with SRAM_BANK_CLEAR_EN defined.
package sram_bank_pkg;

  localparam int unsigned StateW   = 3;
  localparam int unsigned MaxDataW = 1024;

  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StPch   = 3'd1;
  localparam state_t StSense = 3'd2;
  localparam state_t StDone  = 3'd3;
  localparam state_t StClear = 3'd4;

  function automatic int unsigned col_w(int unsigned cols);
    return $clog2(cols);
  endfunction

  function automatic int unsigned addr_w(int unsigned rows, int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Undriven bitlines stay precharged high, so a missing cell reads as all ones.
  function automatic logic [MaxDataW-1:0] no_cell_word(int unsigned w);
    logic [MaxDataW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxDataW; i++) begin
      v[i] = (i < w);
    end
    return v;
  endfunction

endpackage

// File: rtl/sram_bank_ctl_if.sv
// Request/response bundle between a requester and one sram_bank_ctl.
interface sram_bank_ctl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 7
);
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, done, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ready, done, rvalid, rdata);
endinterface

// File: rtl/sram_col_sel.sv
// Combinational row/column decode: splits a word address, flags row validity and
// picks one DATA_W word out of a COLS-wide row.
module sram_col_sel
  import sram_bank_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 32,
  parameter int unsigned COLS   = 4,
  localparam int unsigned AW    = addr_w(ROWS, COLS),
  localparam int unsigned RW    = idx_w(ROWS)
) (
  input  logic [AW-1:0]          addr_i,
  input  logic [COLS*DATA_W-1:0] row_i,
  output logic [DATA_W-1:0]      word_o,
  output logic [RW-1:0]          row_idx_o,
  output logic [COLS-1:0]        col_en_o,
  output logic                   valid_o
);

  localparam int unsigned CW = col_w(COLS);

  logic [AW-1:0] row_full;
  logic [AW-1:0] col_full;

  assign row_full  = addr_i >> CW;
  assign col_full  = addr_i & AW'(COLS - 1);
  assign row_idx_o = RW'(row_full);
  // COLS is a power of two, so row < ROWS is exactly addr < ROWS*COLS.
  assign valid_o   = 32'(row_full) < ROWS;

  always_comb begin
    col_en_o = '0;
    word_o   = '0;
    for (int c = 0; c < COLS; c++) begin
      col_en_o[c] = valid_o && (col_full == AW'(c));
      if (col_en_o[c]) begin
        word_o = row_i[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/sram_bank_ctl.sv
// Sequenced SRAM bank: precharge, column select, sense/write, data latch per access.
// Define SRAM_BANK_CLEAR_EN to zero the whole array after every reset release.
module sram_bank_ctl
  import sram_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned COLS       = 4,
  parameter int unsigned PCH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           n_reset,
  sram_bank_ctl_if.slave bus
);

  localparam int unsigned AW    = addr_w(ROWS, COLS);
  localparam int unsigned RW    = idx_w(ROWS);
  localparam int unsigned CntW  = idx_w(PCH_CYCLES);
  localparam int unsigned Words = ROWS * COLS;
  localparam logic [DATA_W-1:0] NoCell = DATA_W'(no_cell_word(DATA_W));

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [AW-1:0]          addr_q;
  logic                   we_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [COLS*DATA_W-1:0] mem_q [ROWS];

  logic                   accept;
  logic [AW-1:0]          wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_en;
  logic [RW-1:0]          row_idx;
  logic [COLS-1:0]        wr_col_en;
  logic                   wr_valid;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_word;
  logic [COLS*DATA_W-1:0] row_cur, row_new;
  logic [DATA_W-1:0]      unused_wr_word;
  logic [RW-1:0]          unused_rd_row;
  logic [COLS-1:0]        unused_rd_col;

  assign accept = (state_q == StIdle) && bus.req;

`ifdef SRAM_BANK_CLEAR_EN
  logic [AW-1:0] clr_q, clr_d;

  // The clear sweep borrows the normal write port, one word per cycle.
  assign wr_addr = (state_q == StClear) ? clr_q : addr_q;
  assign wr_data = (state_q == StClear) ? '0 : wdata_q;
  assign wr_en   = (state_q == StClear) || ((state_q == StSense) && we_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clr_q <= '0;
    end else begin
      clr_q <= clr_d;
    end
  end
`else
  assign wr_addr = addr_q;
  assign wr_data = wdata_q;
  assign wr_en   = (state_q == StSense) && we_q;
`endif

  sram_col_sel #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_wr_sel (
    .addr_i    (wr_addr),
    .row_i     ('0),
    .word_o    (unused_wr_word),
    .row_idx_o (row_idx),
    .col_en_o  (wr_col_en),
    .valid_o   (wr_valid)
  );

  assign row_cur = mem_q[row_idx];

  sram_col_sel #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_rd_sel (
    .addr_i    (addr_q),
    .row_i     (row_cur),
    .word_o    (rd_word),
    .row_idx_o (unused_rd_row),
    .col_en_o  (unused_rd_col),
    .valid_o   (rd_valid)
  );

  always_comb begin
    row_new = row_cur;
    for (int c = 0; c < COLS; c++) begin
      if (wr_col_en[c]) begin
        row_new[c*DATA_W +: DATA_W] = wr_data;
      end
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_valid) begin
      mem_q[row_idx] <= row_new;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef SRAM_BANK_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StPch;
          cnt_d   = CntW'(PCH_CYCLES - 1);
        end
      end
      StPch: begin
        if (cnt_q == '0) begin
          state_d = StSense;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSense: begin
        if (!we_q) begin
          rdata_d = rd_valid ? rd_word : NoCell;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
`ifdef SRAM_BANK_CLEAR_EN
      StClear: begin
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(Words - 1)) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
`ifdef SRAM_BANK_CLEAR_EN
      state_q <= StClear;
`else
      state_q <= StIdle;
`endif
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.addr;
      we_q    <= bus.we;
      wdata_q <= bus.wdata;
    end
  end

  assign bus.ready  = (state_q == StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.rvalid = (state_q == StDone) && !we_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_sram_bank_ctl.sv
// Randomised self-checking bench for sram_bank_ctl against a word-array reference model.
module tb_sram_bank_ctl;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned COLS       = 4;
  localparam int unsigned PCH_CYCLES = 1;
  localparam int unsigned AW         = 7;
  localparam int unsigned WORDS      = ROWS * COLS;
  // Edges after the accept edge until done is visible (accept edge itself not counted).
  localparam int          LAT        = PCH_CYCLES + 1;
`ifdef SRAM_BANK_CLEAR_EN
  localparam logic RDY_IN_RESET = 1'b0;
`else
  localparam logic RDY_IN_RESET = 1'b1;
`endif

  logic clk = 1'b0;
  logic n_reset;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  logic [7:0] model_mem [WORDS];
  bit         known [WORDS];
  logic [7:0] model_rdata;
  bit         rdata_known;

  always #5 clk = ~clk;

  sram_bank_ctl_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  sram_bank_ctl #(
    .DATA_W     (DATA_W),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .PCH_CYCLES (PCH_CYCLES)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    model_rdata = 8'h00;
    rdata_known = 1'b1;
`ifdef SRAM_BANK_CLEAR_EN
    for (int i = 0; i < WORDS; i++) begin
      model_mem[i] = 8'h00;
      known[i]     = 1'b1;
    end
`endif
  endtask

  task automatic model_apply(input bit w, input logic [AW-1:0] a, input logic [7:0] d);
    if (w) begin
      if (a < WORDS) begin
        model_mem[a] = d;
        known[a]     = 1'b1;
      end
    end else if (a >= WORDS) begin
      model_rdata = 8'hFF;
      rdata_known = 1'b1;
    end else begin
      model_rdata = model_mem[a];
      rdata_known = known[a];
    end
  endtask

  // Issues one access starting at a negedge and returns what was observed around done.
  task automatic access(input bit w, input logic [AW-1:0] a, input logic [7:0] d,
                        output int lat, output logic rv, output logic [7:0] rd,
                        output logic rdy_busy, output logic done_after,
                        output logic rdy_after);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.req   = 1'b0;
    bus.we    = 1'($urandom);
    bus.addr  = AW'($urandom);
    bus.wdata = 8'($urandom);
    rdy_busy  = bus.ready;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    rv = bus.rvalid;
    rd = bus.rdata;
    @(negedge clk);
    done_after = bus.done;
    rdy_after  = bus.ready;
  endtask

  task automatic test_reset();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    n_reset   = 1'b1;
    #1 n_reset = 1'b0;
    #1;
    checks++; if (bus.ready !== RDY_IN_RESET)
      begin errors++; $display("FAIL reset_ready: got %b expected %b", bus.ready, RDY_IN_RESET); end
    checks++; if (bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.rvalid !== 1'b0)
      begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
    checks++; if (bus.rdata !== 8'h00)
      begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

`ifdef SRAM_BANK_CLEAR_EN
  task automatic test_clear();
    int n;
    int lat;
    logic rv, rb, da, ra;
    logic [7:0] rd;
    logic [AW-1:0] addrs [4];
    logic [7:0] exps [4];
    addrs = '{AW'(0), AW'(64), AW'(WORDS - 1), AW'(127)};
    exps  = '{8'h00, 8'h00, 8'h00, 8'hFF};
    n = 0;
    while (bus.ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== WORDS)
      begin errors++; $display("FAIL clear_cycles: got %0d expected %0d", n, WORDS); end
    checks++; if (done_seen !== 0)
      begin errors++; $display("FAIL clear_no_done: got %0d expected 0", done_seen); end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, addrs[i], 8'h00, lat, rv, rd, rb, da, ra);
      checks++; if (rd !== exps[i])
        begin errors++; $display("FAIL clear_read[%0h]: got %h expected %h", addrs[i], rd, exps[i]); end
    end
    model_apply(1'b0, AW'(127), 8'h00);
  endtask
`endif

  task automatic test_write_read();
    int lat;
    logic rv, rb, da, ra;
    logic [7:0] rd;
    access(1'b1, AW'(5), 8'hA5, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(5), 8'hA5);
    checks++; if (lat !== LAT)
      begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rv !== 1'b0)
      begin errors++; $display("FAIL wr_rvalid: got %b expected 0", rv); end
    checks++; if (rb !== 1'b0)
      begin errors++; $display("FAIL wr_ready_busy: got %b expected 0", rb); end
    checks++; if (da !== 1'b0 || ra !== 1'b1)
      begin errors++; $display("FAIL wr_after_done: got done=%b ready=%b expected done=0 ready=1", da, ra); end
    access(1'b0, AW'(5), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(5), 8'h00);
    checks++; if (lat !== LAT)
      begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rv !== 1'b1)
      begin errors++; $display("FAIL rd_rvalid: got %b expected 1", rv); end
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL rd_data: got %h expected %h", rd, model_rdata); end
    checks++; if (da !== 1'b0 || ra !== 1'b1)
      begin errors++; $display("FAIL rd_after_done: got done=%b ready=%b expected done=0 ready=1", da, ra); end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic rv, rb, da, ra;
    logic [7:0] rd, d0, dl;
    d0 = 8'($urandom);
    dl = 8'($urandom);
    access(1'b1, AW'(0), d0, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(0), d0);
    access(1'b1, AW'(WORDS - 1), dl, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(WORDS - 1), dl);
    access(1'b1, AW'(8'h7F), 8'h12, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(8'h7F), 8'h12);
    checks++; if (lat !== LAT || rv !== 1'b0)
      begin errors++; $display("FAIL oor_write: got lat=%0d rvalid=%b expected lat=%0d rvalid=0", lat, rv, LAT); end
    access(1'b0, AW'(8'h7F), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(8'h7F), 8'h00);
    checks++; if (rd !== 8'hFF || rv !== 1'b1)
      begin errors++; $display("FAIL oor_read_7f: got rdata=%h rvalid=%b expected FF 1", rd, rv); end
    access(1'b0, AW'(WORDS), 8'h00, lat, rv, rd, rb, da, ra);
    checks++; if (rd !== 8'hFF)
      begin errors++; $display("FAIL oor_read_first: got %h expected FF", rd); end
    access(1'b0, AW'(WORDS - 1), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(WORDS - 1), 8'h00);
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL last_word: got %h expected %h", rd, model_rdata); end
    access(1'b0, AW'(0), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(0), 8'h00);
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL word0_intact: got %h expected %h", rd, model_rdata); end
  endtask

  task automatic test_ignored_req();
    int lat;
    int snap;
    logic rv, rb, da, ra;
    logic [7:0] rd;
    access(1'b1, AW'(9), 8'h99, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(9), 8'h99);
    snap = done_seen;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = AW'(2);
    bus.wdata = 8'h3C;
    @(negedge clk);
    bus.addr  = AW'(9);
    bus.wdata = 8'hEE;
    @(negedge clk);
    bus.req = 1'b0;
    model_apply(1'b1, AW'(2), 8'h3C);
    repeat (6) @(negedge clk);
    #1;
    checks++; if (done_seen - snap !== 1)
      begin errors++; $display("FAIL ignored_req_dones: got %0d expected 1", done_seen - snap); end
    @(negedge clk);
    access(1'b0, AW'(9), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(9), 8'h00);
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL ignored_req_no_write: got %h expected %h", rd, model_rdata); end
    access(1'b0, AW'(2), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(2), 8'h00);
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL raw_addr2: got %h expected %h", rd, model_rdata); end
    access(1'b1, AW'(3), 8'h44, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(3), 8'h44);
    repeat (3) @(negedge clk);
    checks++; if (bus.rdata !== model_rdata)
      begin errors++; $display("FAIL rdata_hold: got %h expected %h", bus.rdata, model_rdata); end
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    n = 0;
    first = -1;
    second = -1;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = AW'(2);
    while (second < 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    bus.req = 1'b0;
    checks++; if (second < 0 || second - first !== PCH_CYCLES + 3)
      begin errors++; $display("FAIL b2b_interval: got %0d expected %0d", second - first, PCH_CYCLES + 3); end
    checks++; if (bus.rdata !== model_rdata)
      begin errors++; $display("FAIL b2b_rdata: got %h expected %h", bus.rdata, model_rdata); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int lat;
    int n;
    int snap;
    logic rv, rb, da, ra;
    logic [7:0] rd;
    access(1'b1, AW'(7), 8'h11, lat, rv, rd, rb, da, ra);
    model_apply(1'b1, AW'(7), 8'h11);
    access(1'b0, AW'(7), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(7), 8'h00);
    snap = done_seen;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = AW'(7);
    bus.wdata = 8'h55;
    @(negedge clk);
    bus.req = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    checks++; if (bus.ready !== RDY_IN_RESET || bus.done !== 1'b0 || bus.rvalid !== 1'b0)
      begin errors++; $display("FAIL abort_outputs: got ready=%b done=%b rvalid=%b", bus.ready, bus.done, bus.rvalid); end
    checks++; if (bus.rdata !== 8'h00)
      begin errors++; $display("FAIL abort_rdata: got %h expected 00", bus.rdata); end
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    n = 0;
    while (bus.ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (done_seen !== snap)
      begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", done_seen - snap, 0); end
    @(negedge clk);
    access(1'b0, AW'(7), 8'h00, lat, rv, rd, rb, da, ra);
    model_apply(1'b0, AW'(7), 8'h00);
    checks++; if (rd !== model_rdata)
      begin errors++; $display("FAIL abort_not_committed: got %h expected %h", rd, model_rdata); end
  endtask

  task automatic test_random();
    int lat;
    logic rv, rb, da, ra;
    logic [7:0] rd, d;
    logic [AW-1:0] a;
    bit w;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 15));
      d = 8'($urandom);
      access(w, a, d, lat, rv, rd, rb, da, ra);
      model_apply(w, a, d);
      checks++; if (lat !== LAT || rb !== 1'b0 || ra !== 1'b1)
        begin errors++; $display("FAIL rnd_timing[%0d]: got lat=%0d busy=%b after=%b", i, lat, rb, ra); end
      checks++; if (rv !== !w)
        begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", i, rv, !w); end
      if (rdata_known) begin
        checks++; if (rd !== model_rdata)
          begin errors++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", i, a, rd, model_rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef SRAM_BANK_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_out_of_range();
    test_ignored_req();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
